multdiv_sequencer: RTL and testbench

Controller that sequences the shared multi-cycle multiply/divide unit from the execute stage. It detects a mult/div in the D/X latch, issues a one-cycle start to the unit, and freezes PC, F/D and D/X while the operation runs. It captures the result, destination register and exception flag, presents them for one cycle for writeback, and bounds every operation with a watchdog.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/multdiv_decode.sv | 29 ++
 rtl/multdiv_sequencer.sv | 138 +++++++++++++
 tb/tb_multdiv_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: R-type opcode, mult/div ALU op codes and the
// encoding of the mult/div sequencer states.
package cpu_pkg;

  // Instruction field values
  localparam logic [4:0] OpcodeRType = 5'b00000;
  localparam logic [4:0] AluOpMult   = 5'b00110;
  localparam logic [4:0] AluOpDiv    = 5'b00111;

  // Sequencer state encoding
  typedef logic [1:0] md_state_t;
  localparam md_state_t StIdle  = 2'b00;
  localparam md_state_t StIssue = 2'b01;
  localparam md_state_t StBusy  = 2'b10;
  localparam md_state_t StDone  = 2'b11;

endpackage

// File: rtl/multdiv_decode.sv
// Combinational mult/div decode of an instruction word. Shared between the
// mult/div sequencer and the hazard logic.
//   instruction_i : instruction word
//   is_mult_o     : R-type with aluop == MULT
//   is_div_o      : R-type with aluop == DIV
//   rd_o          : destination register field [26:22]
module multdiv_decode
  import cpu_pkg::*;
(
  input  logic [31:0] instruction_i,
  output logic        is_mult_o,
  output logic        is_div_o,
  output logic [4:0]  rd_o
);

  logic       is_rtype;
  logic [4:0] aluop;
  logic       unused_bits;

  assign is_rtype  = (instruction_i[31:27] == OpcodeRType);
  assign aluop     = instruction_i[6:2];
  assign is_mult_o = is_rtype && (aluop == AluOpMult);
  assign is_div_o  = is_rtype && (aluop == AluOpDiv);
  assign rd_o      = instruction_i[26:22];

  // Fields this decoder does not look at
  assign unused_bits = ^{instruction_i[21:7], instruction_i[1:0]};

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the shared multi-cycle multiply/divide unit from the execute
// stage. On a mult/div in D/X it freezes the front of the pipe, pulses a
// one-cycle start to the unit, waits for the result (bounded by a watchdog)
// and presents result/rd/exception with a one-cycle writeback strobe.
//   clock, reset       : rising-edge clock, async active-low reset
//   dx_instruction     : instruction in the D/X latch
//   dx_valid           : D/X holds a real instruction
//   hold               : interrupt hold, blocks starting a new operation
//   unit_ready         : unit result valid (with unit_result/unit_exception)
//   ctrl_mult/ctrl_div : one-cycle start pulses
//   stall              : freeze PC, F/D and D/X
//   busy               : operation in ISSUE or BUSY
//   result_valid       : one-cycle writeback strobe
//   result_data/rd/exception : latched result, held until the next capture
module multdiv_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_instruction,
  input  logic        dx_valid,
  input  logic        hold,
  input  logic        unit_ready,
  input  logic        unit_exception,
  input  logic [31:0] unit_result,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result_data,
  output logic [4:0]  result_rd,
  output logic        result_exception
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  logic            dec_is_mult;
  logic            dec_is_div;
  logic [4:0]      dec_rd;
  logic            is_md;

  md_state_t       state_q, state_d;
  logic            is_div_q, is_div_d;
  logic [4:0]      rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     res_data_q, res_data_d;
  logic [4:0]      res_rd_q, res_rd_d;
  logic            res_exc_q, res_exc_d;

  multdiv_decode u_decode (
    .instruction_i (dx_instruction),
    .is_mult_o     (dec_is_mult),
    .is_div_o      (dec_is_div),
    .rd_o          (dec_rd)
  );

  assign is_md = dx_valid && (dec_is_mult || dec_is_div);

  always_comb begin
    state_d    = state_q;
    is_div_d   = is_div_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    res_exc_d  = res_exc_q;
    unique case (state_q)
      StIdle: begin
        if (is_md && !hold) begin
          is_div_d = dec_is_div;
          rd_d     = dec_rd;
          cnt_d    = '0;
          state_d  = StIssue;
        end
      end
      // unit_ready is deliberately ignored here; the unit was only just started
      StIssue: state_d = StBusy;
      StBusy: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (unit_ready) begin
          res_data_d = unit_result;
          res_exc_d  = unit_exception;
          res_rd_d   = rd_q;
          state_d    = StDone;
        end else if (cnt_q == CntLast) begin
          // Watchdog abort: report as an exception with a zero result
          res_data_d = '0;
          res_exc_d  = 1'b1;
          res_rd_d   = rd_q;
          state_d    = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      is_div_q   <= 1'b0;
      rd_q       <= '0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_exc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_div_q   <= is_div_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      res_exc_q  <= res_exc_d;
    end
  end

  assign ctrl_mult    = (state_q == StIssue) && !is_div_q;
  assign ctrl_div     = (state_q == StIssue) && is_div_q;
  assign busy         = (state_q == StIssue) || (state_q == StBusy);
  assign result_valid = (state_q == StDone);

  // Independent of hold so a blocked op keeps the pipe frozen; gated by reset
  // so every output reads 0 while reset is asserted.
  assign stall = reset && (((state_q == StIdle) && is_md) || busy);

  assign result_data      = res_data_q;
  assign result_rd        = res_rd_q;
  assign result_exception = res_exc_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer (TIMEOUT = 8). Each task walks a
// scenario cycle by cycle: inputs change 1 time unit after the rising edge,
// outputs are compared 2 units later.
module tb_multdiv_sequencer;

  localparam int unsigned TIMEOUT = 8;
  localparam logic [4:0] MULT = 5'b00110;
  localparam logic [4:0] DIV  = 5'b00111;

  logic        clock;
  logic        reset;
  logic [31:0] dx_instruction;
  logic        dx_valid;
  logic        hold;
  logic        unit_ready;
  logic        unit_exception;
  logic [31:0] unit_result;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_exception;

  int n_checks;
  int n_fail;

  multdiv_sequencer #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .dx_instruction   (dx_instruction),
    .dx_valid         (dx_valid),
    .hold             (hold),
    .unit_ready       (unit_ready),
    .unit_exception   (unit_exception),
    .unit_result      (unit_result),
    .ctrl_mult        (ctrl_mult),
    .ctrl_div         (ctrl_div),
    .stall            (stall),
    .busy             (busy),
    .result_valid     (result_valid),
    .result_data      (result_data),
    .result_rd        (result_rd),
    .result_exception (result_exception)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mk_instr(input logic [4:0] op, input logic [4:0] rd,
                                           input logic [4:0] alu);
    return {op, rd, 15'h0, alu, 2'b00};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Control vector order: {stall, busy, ctrl_mult, ctrl_div, result_valid}
  task automatic test_reset();
    reset          = 1'b0;
    dx_valid       = 1'b1;
    dx_instruction = mk_instr(5'b0, 5'd3, MULT);
    hold           = 1'b0;
    unit_ready     = 1'b0;
    unit_exception = 1'b0;
    unit_result    = 32'h0;
    #2;
    n_checks++;
    if ({stall, busy, ctrl_mult, ctrl_div, result_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {stall, busy, ctrl_mult, ctrl_div, result_valid});
    end
    n_checks++;
    if ({result_data, result_rd, result_exception} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_result: got data=%h rd=%0d exc=%b want all 0",
               result_data, result_rd, result_exception);
    end
    dx_valid = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      #2;
      n_checks++;
      if ({stall, busy, ctrl_mult, ctrl_div, result_valid} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: got %b want 00000", c,
                 {stall, busy, ctrl_mult, ctrl_div, result_valid});
      end
    end
  endtask

  task automatic test_mult();
    logic [4:0] exp;
    for (int c = 0; c <= 8; c++) begin
      tick();
      dx_valid       = (c <= 7);
      dx_instruction = mk_instr(5'b0, 5'd3, MULT);
      unit_ready     = (c == 6);
      unit_exception = 1'b0;
      unit_result    = (c == 6) ? 32'h0000_0015 : 32'hFFFF_FFFF;
      #2;
      exp = {c <= 6, (c >= 1 && c <= 6), c == 1, 1'b0, c == 7};
      n_checks++;
      if ({stall, busy, ctrl_mult, ctrl_div, result_valid} !== exp) begin
        n_fail++;
        $display("FAIL mult_ctrl c%0d: got %b want %b", c,
                 {stall, busy, ctrl_mult, ctrl_div, result_valid}, exp);
      end
      if (c >= 7) begin
        n_checks++;
        if ({result_data, result_rd, result_exception} !== {32'h15, 5'd3, 1'b0}) begin
          n_fail++;
          $display("FAIL mult_result c%0d: got data=%h rd=%0d exc=%b want 15/3/0",
                   c, result_data, result_rd, result_exception);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    logic [4:0] exp;
    for (int c = 0; c <= 5; c++) begin
      tick();
      dx_valid       = (c <= 4);
      dx_instruction = mk_instr(5'b0, 5'd5, DIV);
      // Ready in ISSUE (c1) must be ignored
      unit_ready     = (c == 1 || c == 3);
      unit_exception = (c == 1 || c == 3);
      unit_result    = 32'hDEAD_BEEF;
      #2;
      exp = {c <= 3, (c >= 1 && c <= 3), 1'b0, c == 1, c == 4};
      n_checks++;
      if ({stall, busy, ctrl_mult, ctrl_div, result_valid} !== exp) begin
        n_fail++;
        $display("FAIL div0_ctrl c%0d: got %b want %b", c,
                 {stall, busy, ctrl_mult, ctrl_div, result_valid}, exp);
      end
      if (c == 4) begin
        n_checks++;
        if ({result_data, result_rd, result_exception} !== {32'hDEAD_BEEF, 5'd5, 1'b1}) begin
          n_fail++;
          $display("FAIL div0_result: got data=%h rd=%0d exc=%b want deadbeef/5/1",
                   result_data, result_rd, result_exception);
        end
      end
    end
  endtask

  // ready_cycle < 0 means the unit never answers
  task automatic test_timeout(input int ready_cycle, input logic [4:0] rd,
                              input logic [31:0] exp_data, input logic exp_exc);
    logic [4:0] exp;
    for (int c = 0; c <= 11; c++) begin
      tick();
      dx_valid       = (c <= 10);
      dx_instruction = mk_instr(5'b0, rd, MULT);
      unit_ready     = (c == ready_cycle);
      unit_exception = 1'b0;
      unit_result    = 32'h0000_1234;
      #2;
      exp = {c <= 9, (c >= 1 && c <= 9), c == 1, 1'b0, c == 10};
      n_checks++;
      if ({stall, busy, ctrl_mult, ctrl_div, result_valid} !== exp) begin
        n_fail++;
        $display("FAIL timeout_ctrl rdy=%0d c%0d: got %b want %b", ready_cycle, c,
                 {stall, busy, ctrl_mult, ctrl_div, result_valid}, exp);
      end
      if (c == 10) begin
        n_checks++;
        if ({result_data, result_rd, result_exception} !== {exp_data, rd, exp_exc}) begin
          n_fail++;
          $display("FAIL timeout_result rdy=%0d: got data=%h rd=%0d exc=%b want %h/%0d/%b",
                   ready_cycle, result_data, result_rd, result_exception,
                   exp_data, rd, exp_exc);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [4:0] exp;
    for (int c = 0; c <= 10; c++) begin
      tick();
      dx_valid       = (c <= 9);
      dx_instruction = mk_instr(5'b0, 5'd2, MULT);
      hold           = (c <= 4);
      unit_ready     = (c == 8);
      unit_exception = 1'b0;
      unit_result    = 32'h0000_ABCD;
      #2;
      exp = {c <= 8, (c >= 6 && c <= 8), c == 6, 1'b0, c == 9};
      n_checks++;
      if ({stall, busy, ctrl_mult, ctrl_div, result_valid} !== exp) begin
        n_fail++;
        $display("FAIL hold_ctrl c%0d: got %b want %b", c,
                 {stall, busy, ctrl_mult, ctrl_div, result_valid}, exp);
      end
      if (c == 9) begin
        n_checks++;
        if ({result_data, result_rd, result_exception} !== {32'h0000_ABCD, 5'd2, 1'b0}) begin
          n_fail++;
          $display("FAIL hold_result: got data=%h rd=%0d exc=%b want abcd/2/0",
                   result_data, result_rd, result_exception);
        end
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    for (int c = 0; c <= 14; c++) begin
      tick();
      if (c <= 4) begin
        dx_valid = 1'b1; dx_instruction = mk_instr(5'b0, 5'd1, MULT);
      end else if (c <= 9) begin
        dx_valid = 1'b1; dx_instruction = mk_instr(5'b0, 5'd6, DIV);
      end else if (c == 11) begin
        dx_valid = 1'b1; dx_instruction = mk_instr(5'b0, 5'd4, 5'b00000);
      end else if (c == 12) begin
        dx_valid = 1'b0; dx_instruction = mk_instr(5'b0, 5'd4, MULT);
      end else if (c == 13) begin
        dx_valid = 1'b1; dx_instruction = mk_instr(5'b00001, 5'd4, MULT);
      end else begin
        dx_valid = 1'b0;
      end
      unit_ready     = (c == 3 || c == 8);
      unit_exception = 1'b0;
      unit_result    = (c == 3) ? 32'h11 : 32'h22;
      #2;
      exp = {(c <= 3) || (c >= 5 && c <= 8), (c >= 1 && c <= 3) || (c >= 6 && c <= 8),
             c == 1, c == 6, (c == 4 || c == 9)};
      n_checks++;
      if ({stall, busy, ctrl_mult, ctrl_div, result_valid} !== exp) begin
        n_fail++;
        $display("FAIL b2b_ctrl c%0d: got %b want %b", c,
                 {stall, busy, ctrl_mult, ctrl_div, result_valid}, exp);
      end
      if (c == 4) begin
        n_checks++;
        if ({result_data, result_rd} !== {32'h11, 5'd1}) begin
          n_fail++;
          $display("FAIL b2b_first: got data=%h rd=%0d want 11/1", result_data, result_rd);
        end
      end
      if (c == 9) begin
        n_checks++;
        if ({result_data, result_rd} !== {32'h22, 5'd6}) begin
          n_fail++;
          $display("FAIL b2b_second: got data=%h rd=%0d want 22/6", result_data, result_rd);
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [4:0] exp;
    for (int c = 0; c <= 3; c++) begin
      tick();
      dx_valid       = 1'b1;
      dx_instruction = mk_instr(5'b0, 5'd4, MULT);
      unit_ready     = 1'b0;
      #2;
      exp = {1'b1, c >= 1, c == 1, 1'b0, 1'b0};
      n_checks++;
      if ({stall, busy, ctrl_mult, ctrl_div, result_valid} !== exp) begin
        n_fail++;
        $display("FAIL midop_ctrl c%0d: got %b want %b", c,
                 {stall, busy, ctrl_mult, ctrl_div, result_valid}, exp);
      end
    end
    // Abort in BUSY with the op still in D/X
    reset = 1'b0;
    #1;
    n_checks++;
    if ({stall, busy, ctrl_mult, ctrl_div, result_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL midop_abort_ctrl: got %b want 00000",
               {stall, busy, ctrl_mult, ctrl_div, result_valid});
    end
    n_checks++;
    if ({result_data, result_rd, result_exception} !== 38'h0) begin
      n_fail++;
      $display("FAIL midop_abort_result: got data=%h rd=%0d exc=%b want all 0",
               result_data, result_rd, result_exception);
    end
    for (int c = 4; c <= 7; c++) begin
      tick();
      reset      = 1'b1;
      dx_valid   = 1'b0;
      unit_ready = 1'b1;
      #2;
      n_checks++;
      if ({stall, busy, ctrl_mult, ctrl_div, result_valid} !== 5'b0) begin
        n_fail++;
        $display("FAIL midop_after c%0d: got %b want 00000", c,
                 {stall, busy, ctrl_mult, ctrl_div, result_valid});
      end
    end
    unit_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_mult();
    test_div_zero();
    test_timeout(-1, 5'd7, 32'h0, 1'b1);
    test_timeout(9, 5'd9, 32'h0000_1234, 1'b0);
    test_hold();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
